// File: rtl/regbank_ctrl.sv
// Register-bank sequencer: owns the write enables, write data and read
// select of a bank of byte registers and runs one command at a time as a
// fixed multi-cycle sequence (LOAD, MOVE, LDPAIR, INCPAIR).
//
// Handshake: ready is high only in IDLE; a command is taken on a rising
// edge where ready=1 and cmd_stb=1. A strobe while ready=0 is dropped, not
// queued. done pulses for one cycle once the last write has landed in the
// bank.
//
// Pair addressing: pair p maps its high byte to index {p,0} and its low
// byte to index {p,1} (B/C, D/E, H/L ordering).
module regbank_ctrl #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cmd_stb,
  input  logic [1:0]                cmd_op,
  input  logic [ADDRSIZE-1:0]       cmd_dst,
  input  logic [ADDRSIZE-1:0]       cmd_src,
  input  logic [2*DATASIZE-1:0]     cmd_data,
  input  logic [DATASIZE-1:0]       reg_dout,
  output logic                      ready,
  output logic                      done,
  output logic [(2**ADDRSIZE)-1:0]  reg_enb,
  output logic [DATASIZE-1:0]       reg_din,
  output logic [ADDRSIZE-1:0]       reg_sel
);

  localparam int NREG = 2**ADDRSIZE;

  localparam logic [1:0] OP_LOAD    = 2'b00;
  localparam logic [1:0] OP_MOVE    = 2'b01;
  localparam logic [1:0] OP_LDPAIR  = 2'b10;
  localparam logic [1:0] OP_INCPAIR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RD_LO = 3'd1,
    S_RD_HI = 3'd2,
    S_WR_LO = 3'd3,
    S_WR_HI = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t                state_q;
  logic [1:0]            op_q;
  logic [ADDRSIZE-1:0]   dst_q;
  logic [DATASIZE-1:0]   data_lo_q;
  logic [DATASIZE-1:0]   tmp_lo_q;
  logic [DATASIZE-1:0]   tmp_hi_q;
  logic                  carry;

  function automatic logic [NREG-1:0] onehot(input logic [ADDRSIZE-1:0] idx);
    logic [NREG-1:0] r;
    r      = '0;
    r[idx] = 1'b1;
    return r;
  endfunction

  function automatic logic [ADDRSIZE-1:0] hi_idx(input logic [ADDRSIZE-1:0] d);
    return {d[ADDRSIZE-1:1], 1'b0};
  endfunction

  function automatic logic [ADDRSIZE-1:0] lo_idx(input logic [ADDRSIZE-1:0] d);
    return {d[ADDRSIZE-1:1], 1'b1};
  endfunction

  // Carry out of the low byte of a pair increment
  assign carry = (tmp_lo_q == {DATASIZE{1'b1}});

  // Sequencer state, latched command and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      dst_q     <= '0;
      data_lo_q <= '0;
      tmp_lo_q  <= '0;
      tmp_hi_q  <= '0;
      ready     <= 1'b1;
      done      <= 1'b0;
      reg_enb   <= '0;
      reg_din   <= '0;
      reg_sel   <= '0;
    end else begin
      // Enables and done are single-cycle unless a state re-asserts them
      reg_enb <= '0;
      done    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_stb) begin
            op_q      <= cmd_op;
            dst_q     <= cmd_dst;
            data_lo_q <= cmd_data[DATASIZE-1:0];
            ready     <= 1'b0;
            case (cmd_op)
              OP_LOAD: begin
                state_q <= S_WR_LO;
                reg_enb <= onehot(cmd_dst);
                reg_din <= cmd_data[DATASIZE-1:0];
              end
              OP_MOVE: begin
                state_q <= S_RD_LO;
                reg_sel <= cmd_src;
              end
              OP_LDPAIR: begin
                state_q <= S_WR_HI;
                reg_enb <= onehot(hi_idx(cmd_dst));
                reg_din <= cmd_data[2*DATASIZE-1:DATASIZE];
              end
              default: begin
                state_q <= S_RD_LO;
                reg_sel <= lo_idx(cmd_dst);
              end
            endcase
          end
        end
        S_RD_LO: begin
          tmp_lo_q <= reg_dout;
          if (op_q == OP_MOVE) begin
            state_q <= S_WR_LO;
            reg_enb <= onehot(dst_q);
            reg_din <= reg_dout;
          end else begin
            state_q <= S_RD_HI;
            reg_sel <= hi_idx(dst_q);
          end
        end
        S_RD_HI: begin
          tmp_hi_q <= reg_dout;
          state_q  <= S_WR_LO;
          reg_enb  <= onehot(lo_idx(dst_q));
          reg_din  <= tmp_lo_q + {{(DATASIZE-1){1'b0}}, 1'b1};
        end
        S_WR_LO: begin
          if (op_q == OP_INCPAIR) begin
            state_q <= S_WR_HI;
            reg_enb <= onehot(hi_idx(dst_q));
            reg_din <= tmp_hi_q + {{(DATASIZE-1){1'b0}}, carry};
          end else begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_WR_HI: begin
          if (op_q == OP_LDPAIR) begin
            state_q <= S_WR_LO;
            reg_enb <= onehot(lo_idx(dst_q));
            reg_din <= data_lo_q;
          end else begin
            state_q <= S_DONE;
            done    <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          ready   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/regbank_ctrl.md
Name: regbank_ctrl

Overview:
- Sequencer that owns the write enables and read select of a bank of single-byte `register` instances (8085 B,C,D,E,H,L,...).
- Accepts one command at a time from the core's control unit and executes it as a fixed multi-cycle sequence:
  - immediate load
  - register-to-register move
  - 16-bit pair load
  - 16-bit pair increment
- Sits between the instruction decoder and the register bank. It drives each register's enb and data_in and observes the bank's muxed read output.

Parameters:
- DATASIZE, 8, width of one register; must be a multiple of 4.
- ADDRSIZE, 3, register index width; the bank holds 2**ADDRSIZE registers. Pair index is ADDRSIZE-1 bits.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_stb  in  1  command strobe; sampled only while ready=1.
- cmd_op  in  2  00=LOAD, 01=MOVE, 10=LDPAIR, 11=INCPAIR.
- cmd_dst  in  ADDRSIZE  destination register index (pair ops use cmd_dst[ADDRSIZE-1:1]).
- cmd_src  in  ADDRSIZE  source register index (MOVE only).
- cmd_data  in  2*DATASIZE  immediate; LOAD uses low byte; LDPAIR uses {hi,lo}.
- reg_dout  in  DATASIZE  bank read data for the register selected by reg_sel (combinational from bank).
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse: command complete, new value visible on the bank.
- reg_enb  out  2**ADDRSIZE  one-hot write enable to the register instances; all-zero when not writing.
- reg_din  out  DATASIZE  write data, shared by all registers.
- reg_sel  out  ADDRSIZE  read-mux select into the bank.

Behaviour:
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. The state register is binary-encoded.
- All outputs decode from the state and latched registers only. There is no combinational path from cmd_* to any output.
- Reset (rst=1 at an edge):
  - next state is IDLE; ready=1, done=0, reg_enb=0, reg_din=0, reg_sel=0.
  - latched command and tmp_lo/tmp_hi are cleared.
- Accept: in IDLE with cmd_stb=1 at an edge, the controller latches op/dst/src/data and leaves IDLE. cmd_stb while ready=0 is ignored, not queued.
- Pair addressing: for pair p, the high register is index {p,0} and the low register is index {p,1} (B/C, D/E, H/L ordering).
- Sequences (k = accept edge; each state lasts one cycle):
  - LOAD: WR_LO (enb[dst], din=data[DATASIZE-1:0]) -> DONE. done is high in cycle k+2.
  - MOVE: RD_LO (sel=src; tmp_lo<=reg_dout at end of cycle) -> WR_LO (enb[dst], din=tmp_lo) -> DONE. done in cycle k+3.
  - LDPAIR: WR_HI (enb[hi], din=data[2*DATASIZE-1:DATASIZE]) -> WR_LO (enb[lo], din=data low) -> DONE. done in cycle k+3.
  - INCPAIR sequence:
    - RD_LO (sel=lo; capture tmp_lo) -> RD_HI (sel=hi; capture tmp_hi)
    - -> WR_LO (enb[lo], din=tmp_lo+1) -> WR_HI (enb[hi], din=tmp_hi+carry) -> DONE. done in cycle k+5.
    - carry = (tmp_lo == all-ones).
- DONE: done=1, ready=0; unconditionally returns to IDLE. The earliest next accept is the edge ending the first IDLE cycle after DONE.
- Arithmetic: INCPAIR wraps modulo 2**(2*DATASIZE), so FFFF->0000. There are no flags.
- reg_sel holds its last value outside RD states. reg_din is don't-care-free: it holds the last written value when not writing.
- MOVE with src==dst executes normally; the value is unchanged.
- Mid-operation reset:
  - abort to IDLE; no done pulse; reg_enb=0 from the next cycle.
  - no rollback: an LDPAIR or INCPAIR aborted after WR_HI/WR_LO leaves that byte written.
- At most one reg_enb bit is ever high. It is never high in IDLE, RD_*, or DONE.

Test Plan:
- Reset: hold rst 5 cycles mid-INCPAIR -> after release ready=1, reg_enb=0, done=0; register B keeps its last written value.
- LOAD dst=2 data=0x00A5 -> reg_enb=0x04 for exactly 1 cycle; done 2 cycles after accept; D reads 0xA5.
- LDPAIR dst=4 (H/L) data=0x1234 -> enb 0x10 with din 0x12, then enb 0x20 with din 0x34; done at k+3; H=0x12, L=0x34.
- MOVE src=5 dst=0 with L=0x34 -> reg_sel=5 in RD_LO, then enb=0x01 with din=0x34; B=0x34; done at k+3.
- INCPAIR on B/C sequence:
  - with B/C=0x12FF -> B/C=0x1300.
  - then LDPAIR 0xFFFF followed by INCPAIR -> B/C=0x0000; done at k+5.
- cmd_stb held high continuously with alternating commands -> each accepted only in IDLE; none lost or doubled; one done per accept.
